// File: rtl/aes_encrypt_top.sv
// Iterative AES-128 encryption core: one full round per clock, round keys
// expanded on the fly, start/done handshake with a level done flag.
module aes_encrypt_top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] cipher_key,
  output logic [127:0] ciphertext,
  output logic         done
);

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  localparam logic [3:0] LastRound = 4'd10;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // 8*(255-x) == {~x, 3'b000}, so entry x sits at that bit offset.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTable[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  logic         fsm_q;
  logic [127:0] state_q;
  logic [127:0] rkey_q;
  logic [3:0]   round_q;
  logic [127:0] ciphertext_q;
  logic         done_q;

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] rk_next;
  logic [127:0] round_out;
  logic         last_round;

  assign last_round = (round_q == LastRound);

  // SubBytes (16 LUT copies) and ShiftRows; byte i is row i%4, column i/4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb[4*c+r] = sbox(state_q[127-8*(4*c+r) -: 8]);
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    // MixColumns on one column: each output is 2*a ^ 3*b ^ c ^ d in GF(2^8).
    assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  // Key schedule step: SubWord(RotWord(w3)) ^ Rcon, then chained XOR across the words.
  always_comb begin
    logic [31:0] rot;
    logic [31:0] t;
    logic [31:0] w0, w1, w2, w3;
    rot = {rkey_q[23:0], rkey_q[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t   = t ^ {rcon(round_q), 24'h000000};
    w0  = rkey_q[127:96] ^ t;
    w1  = rkey_q[95:64] ^ w0;
    w2  = rkey_q[63:32] ^ w1;
    w3  = rkey_q[31:0] ^ w2;
    rk_next = {w0, w1, w2, w3};
  end

  // Round result: final round skips MixColumns.
  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign round_out[127-8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ rk_next[127-8*i -: 8];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= StIdle;
      state_q      <= '0;
      rkey_q       <= '0;
      round_q      <= '0;
      ciphertext_q <= '0;
      done_q       <= 1'b0;
    end else if (fsm_q == StIdle) begin
      if (start) begin
        state_q <= plaintext ^ cipher_key;
        rkey_q  <= cipher_key;
        round_q <= 4'd1;
        done_q  <= 1'b0;
        fsm_q   <= StBusy;
      end
    end else begin
      state_q <= round_out;
      rkey_q  <= rk_next;
      if (last_round) begin
        ciphertext_q <= round_out;
        done_q       <= 1'b1;
        round_q      <= '0;
        fsm_q        <= StIdle;
      end else begin
        round_q <= round_q + 4'd1;
      end
    end
  end

  assign ciphertext = ciphertext_q;
  assign done       = done_q;

endmodule

// File: tb/tb_aes_encrypt_top.sv
// Directed bench for aes_encrypt_top: known-answer vectors plus start/reset corner cases.
module tb_aes_encrypt_top;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] cipher_key;
  logic [127:0] ciphertext;
  logic         done;

  int total;
  int bad;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  aes_encrypt_top dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .plaintext  (plaintext),
    .cipher_key (cipher_key),
    .ciphertext (ciphertext),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Start one encryption and check latency, result and hold behaviour.
  task automatic run_vec(input string name, input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] ct);
    @(negedge clk);
    start      = 1'b1;
    plaintext  = pt;
    cipher_key = key;
    @(posedge clk);
    #1;
    start      = 1'b0;
    plaintext  = '1;
    cipher_key = '1;
    check({name, " done_clr"}, 128'(done), 128'(1'b0));
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (n == 9) check({name, " done_c9"}, 128'(done), 128'(1'b0));
    end
    check({name, " done_c10"}, 128'(done), 128'(1'b1));
    check({name, " ct"}, ciphertext, ct);
    repeat (3) @(posedge clk);
    #1;
    check({name, " done_hold"}, 128'(done), 128'(1'b1));
    check({name, " ct_hold"}, ciphertext, ct);
  endtask

  initial begin
    logic         prev;
    int           rises;
    int           first;
    total      = 0;
    bad        = 0;
    start      = 1'b0;
    plaintext  = '0;
    cipher_key = '0;
    rst_n      = 1'b0;

    vecs[0] = '{pt: 128'h00112233445566778899aabbccddeeff,
                key: 128'h000102030405060708090a0b0c0d0e0f,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{pt: 128'h3243f6a8885a308d313198a2e0370734,
                key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{pt: 128'h0, key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    repeat (2) @(posedge clk);
    #1;
    check("reset ct", ciphertext, 128'h0);
    check("reset done", 128'(done), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].pt, vecs[i].key, vecs[i].ct);
    end

    // Start pulsed mid-run with another vector must be ignored.
    @(negedge clk);
    start      = 1'b1;
    plaintext  = vecs[0].pt;
    cipher_key = vecs[0].key;
    @(posedge clk);
    #1;
    start = 1'b0;
    prev  = done;
    rises = 0;
    first = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) begin
        start      = 1'b1;
        plaintext  = vecs[1].pt;
        cipher_key = vecs[1].key;
      end else begin
        start = 1'b0;
      end
      if (done && !prev) begin
        rises++;
        if (first == 0) first = n;
      end
      prev = done;
    end
    check("busy_start rises", 128'(rises), 128'(1));
    check("busy_start latency", 128'(first), 128'(10));
    check("busy_start ct", ciphertext, vecs[0].ct);

    // Asynchronous reset during round 5 aborts at once.
    @(negedge clk);
    start      = 1'b1;
    plaintext  = vecs[1].pt;
    cipher_key = vecs[1].key;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset ct", ciphertext, 128'h0);
    check("midreset done", 128'(done), 128'(1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midreset done_stays", 128'(done), 128'(1'b0));
    run_vec("after_reset", vecs[0].pt, vecs[0].key, vecs[0].ct);

    // Start held high: C.1 then App.B captured back to back.
    @(negedge clk);
    start      = 1'b1;
    plaintext  = vecs[0].pt;
    cipher_key = vecs[0].key;
    @(posedge clk);
    #1;
    plaintext  = vecs[1].pt;
    cipher_key = vecs[1].key;
    for (int n = 1; n <= 21; n++) begin
      @(posedge clk);
      #1;
      if (n == 9)  check("b2b done_c9", 128'(done), 128'(1'b0));
      if (n == 10) begin
        check("b2b done1", 128'(done), 128'(1'b1));
        check("b2b ct1", ciphertext, vecs[0].ct);
      end
      if (n == 11) begin
        check("b2b done_clr", 128'(done), 128'(1'b0));
        check("b2b ct1_keep", ciphertext, vecs[0].ct);
      end
      if (n == 20) check("b2b done_c20", 128'(done), 128'(1'b0));
      if (n == 21) begin
        start = 1'b0;
        check("b2b done2", 128'(done), 128'(1'b1));
        check("b2b ct2", ciphertext, vecs[1].ct);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
